// File: rtl/ad_bus_arbiter_if.sv
// Wishbone-style single-master bus between the arbiter and the shared slave.
// The master modport is the arbiter side; the slave modport is the responding peripheral.
interface ad_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [DATA_WIDTH-1:0] wb_dat_o;
   logic [DATA_WIDTH-1:0] wb_dat_i;
   logic                  wb_we_o;
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/ad_bus_arbiter.sv
// Two-requester round-robin arbiter onto one Wishbone-style bus: strobes land in
// per-requester pending slots, one bus cycle runs at a time with an ack timeout.
module ad_bus_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_wr,
   input  logic                  m0_rd,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_done,
   output logic                  m0_err,
   output logic                  m0_overrun,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_wr,
   input  logic                  m1_rd,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_done,
   output logic                  m1_err,
   output logic                  m1_overrun,
   output logic                  grant_o,
   ad_bus_arbiter_if.master      wb
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t                         state_q, state_d;
   logic [7:0]                     cnt_q, cnt_d;
   logic                           grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]          adr_q, adr_d;
   logic [DATA_WIDTH-1:0]          dat_q, dat_d;
   logic                           we_q, we_d;
   logic                           stb_q, stb_d;
   logic [1:0]                     valid_q, valid_d;
   logic [1:0][ADDR_WIDTH-1:0]     slot_addr_q, slot_addr_d;
   logic [1:0][DATA_WIDTH-1:0]     slot_wdata_q, slot_wdata_d;
   logic [1:0]                     slot_we_q, slot_we_d;
   logic [1:0][DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [1:0]                     done_q, done_d;
   logic [1:0]                     err_q, err_d;
   logic [1:0]                     overrun_q, overrun_d;

   logic [1:0]                     req_stb_s;
   logic [1:0]                     req_wr_s;
   logic [1:0][ADDR_WIDTH-1:0]     req_addr_s;
   logic [1:0][DATA_WIDTH-1:0]     req_wdata_s;
   logic                           fin_s;
   logic                           tmo_s;
   logic                           sel_s;
   logic [1:0]                     clr_s;

   assign req_stb_s   = {m1_wr | m1_rd, m0_wr | m0_rd};
   assign req_wr_s    = {m1_wr, m0_wr};
   assign req_addr_s  = {m1_addr, m0_addr};
   assign req_wdata_s = {m1_wdata, m0_wdata};

   // Next-state logic for the bus FSM, the pending slots and all registered outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      we_d         = we_q;
      stb_d        = stb_q;
      valid_d      = valid_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      slot_we_d    = slot_we_q;
      rdata_d      = rdata_q;
      done_d       = 2'b00;
      err_d        = 2'b00;
      overrun_d    = overrun_q;
      fin_s        = 1'b0;
      tmo_s        = 1'b0;
      sel_s        = grant_q;
      clr_s        = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (valid_q != 2'b00) begin
               // On a tie the requester that did not own the last cycle wins.
               if (valid_q == 2'b11) begin
                  sel_s = ~grant_q;
               end else begin
                  sel_s = valid_q[1];
               end
               grant_d = sel_s;
               adr_d   = slot_addr_q[sel_s];
               dat_d   = slot_wdata_q[sel_s];
               we_d    = slot_we_q[sel_s];
               stb_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = ST_BUS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (wb.wb_ack_i) begin
               fin_s = 1'b1;
               if (!we_q) begin
                  rdata_d[grant_q] = wb.wb_dat_i;
               end else begin
                  rdata_d[grant_q] = rdata_q[grant_q];
               end
            end else if (cnt_q == TO_LAST) begin
               fin_s = 1'b1;
               tmo_s = 1'b1;
               if (!we_q) begin
                  rdata_d[grant_q] = {DATA_WIDTH{1'b1}};
               end else begin
                  rdata_d[grant_q] = rdata_q[grant_q];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
            if (fin_s) begin
               stb_d            = 1'b0;
               done_d[grant_q]  = 1'b1;
               err_d[grant_q]   = tmo_s;
               state_d          = ST_IDLE;
            end else begin
               state_d = ST_BUS;
            end
         end
         default: begin
            stb_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // A strobe arriving while the owning slot retires refills it instead of overrunning.
      for (int i = 0; i < 2; i++) begin
         clr_s[i] = fin_s && (grant_q == 1'(i));
         if (req_stb_s[i] && (!valid_q[i] || clr_s[i])) begin
            valid_d[i]      = 1'b1;
            slot_addr_d[i]  = req_addr_s[i];
            slot_wdata_d[i] = req_wdata_s[i];
            slot_we_d[i]    = req_wr_s[i];
         end else if (req_stb_s[i]) begin
            overrun_d[i] = 1'b1;
         end else if (clr_s[i]) begin
            valid_d[i] = 1'b0;
         end else begin
            valid_d[i] = valid_q[i];
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         grant_q      <= 1'b1;
         adr_q        <= {ADDR_WIDTH{1'b0}};
         dat_q        <= {DATA_WIDTH{1'b0}};
         we_q         <= 1'b0;
         stb_q        <= 1'b0;
         valid_q      <= 2'b00;
         slot_addr_q  <= {(2*ADDR_WIDTH){1'b0}};
         slot_wdata_q <= {(2*DATA_WIDTH){1'b0}};
         slot_we_q    <= 2'b00;
         rdata_q      <= {(2*DATA_WIDTH){1'b0}};
         done_q       <= 2'b00;
         err_q        <= 2'b00;
         overrun_q    <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         we_q         <= we_d;
         stb_q        <= stb_d;
         valid_q      <= valid_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         slot_we_q    <= slot_we_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = stb_q;
   assign wb.wb_stb_o = stb_q;
   assign grant_o     = grant_q;
   assign m0_rdata    = rdata_q[0];
   assign m1_rdata    = rdata_q[1];
   assign m0_done     = done_q[0];
   assign m1_done     = done_q[1];
   assign m0_err      = err_q[0];
   assign m1_err      = err_q[1];
   assign m0_overrun  = overrun_q[0];
   assign m1_overrun  = overrun_q[1];

endmodule

// File: tb/tb_ad_bus_arbiter.sv
// Bench for ad_bus_arbiter (TIMEOUT=8): table of single transactions plus hand sequences
// for tie-breaking, strobe-in-ack-cycle, overrun and reset during a bus cycle.
module tb_ad_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0, m1_addr = 16'h0, m1_wdata = 16'h0;
   logic        m0_wr = 1'b0, m0_rd = 1'b0, m1_wr = 1'b0, m1_rd = 1'b0;
   logic [15:0] m0_rdata, m1_rdata;
   logic        m0_done, m0_err, m0_overrun, m1_done, m1_err, m1_overrun, grant_o;
   logic [7:0]  ack_at = 8'd1;
   int          stb_run = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   ad_bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   ad_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err), .m0_overrun(m0_overrun),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err), .m1_overrun(m1_overrun),
      .grant_o(grant_o), .wb(bus)
   );

   always #5 clk = ~clk;

   // Slave model: ack on the ack_at-th consecutive stb cycle; ack_at == 0 never acks.
   always @(posedge clk) begin
      if (bus.wb_stb_o && !bus.wb_ack_i) stb_run <= stb_run + 1;
      else stb_run <= 0;
   end
   assign bus.wb_ack_i = bus.wb_stb_o && (ack_at != 8'd0) && (stb_run == int'(ack_at) - 1);

   typedef struct {
      logic        req;
      logic        wr;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] dat_i;
      logic [7:0]  ack_at;
      int          exp_stb;
      logic        exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        req;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Scoreboard: every done pulse is matched in order against queued expectations.
   always @(negedge clk) begin
      if (!rst && (m0_done || m1_done)) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", {30'd0, m1_done, m0_done}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_req", {30'd0, m1_done, m0_done}, mon_e.req ? 32'd2 : 32'd1);
            chk("sb_err", mon_e.req ? m1_err : m0_err, {31'd0, mon_e.err});
            chk("sb_rdata", mon_e.req ? m1_rdata : m0_rdata, {16'd0, mon_e.rdata});
         end
      end
   end

   task automatic strobe(input logic req, input logic wr, input logic rd,
                         input logic [15:0] a, input logic [15:0] d);
      if (!req) begin
         m0_addr = a; m0_wdata = d; m0_wr = wr; m0_rd = rd;
      end else begin
         m1_addr = a; m1_wdata = d; m1_wr = wr; m1_rd = rd;
      end
   endtask

   task automatic unstrobe();
      m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_bus"}, {bus.wb_adr_o, bus.wb_dat_o}, 32'd0);
      chk({tag, "_ctrl"}, {23'd0, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o, m0_done, m0_err,
                           m0_overrun, m1_done, m1_err, m1_overrun}, 32'd0);
      chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 32'd0);
      chk({tag, "_grant"}, {31'd0, grant_o}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   stb_n;
      int   done_k;
      stb_n  = 0;
      done_k = -1;
      @(negedge clk);
      ack_at      = v.ack_at;
      bus.wb_dat_i = v.dat_i;
      strobe(v.req, v.wr, v.rd, v.addr, v.wdata);
      sb.push_back('{v.req, v.exp_err, v.exp_rdata});
      for (int k = 1; k <= 40 && done_k < 0; k++) begin
         @(negedge clk);
         if (k == 1) unstrobe();
         if (bus.wb_stb_o) begin
            if (stb_n == 0) begin
               chk({tag, "_first_stb"}, k, 32'd2);
               chk({tag, "_adr"}, {16'd0, bus.wb_adr_o}, {16'd0, v.addr});
               chk({tag, "_dat"}, {16'd0, bus.wb_dat_o}, {16'd0, v.wdata});
               chk({tag, "_we"}, {31'd0, bus.wb_we_o}, {31'd0, v.wr});
               chk({tag, "_grant"}, {31'd0, grant_o}, {31'd0, v.req});
            end
            chk({tag, "_cyc_eq_stb"}, {31'd0, bus.wb_cyc_o}, 32'd1);
            stb_n++;
         end
         if (m0_done || m1_done) done_k = k;
      end
      chk({tag, "_stb_len"}, stb_n, v.exp_stb);
      chk({tag, "_done_lat"}, done_k, v.exp_stb + 2);
      chk({tag, "_rdata"}, {16'd0, v.req ? m1_rdata : m0_rdata}, {16'd0, v.exp_rdata});
      @(negedge clk);
      chk({tag, "_done_width"}, {30'd0, m1_done, m0_done}, 32'd0);
   endtask

   initial begin
      int   win, dones, last_stb, prev_stb;
      logic sent;
      logic [15:0] win_dat[2];

      bus.wb_dat_i = 16'h0;
      vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'hBEEF, 16'h0000, 8'd1, 1, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'hA5A5, 8'd4, 4, 1'b0, 16'hA5A5};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0050, 16'h0000, 16'h7777, 8'd0, 8, 1'b1, 16'hFFFF};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0051, 16'h0000, 16'h5A5A, 8'd2, 2, 1'b0, 16'h5A5A};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h1357, 16'h9999, 8'd8, 8, 1'b0, 16'hA5A5};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0060, 16'h0000, 16'h0001, 8'd3, 3, 1'b0, 16'h0001};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h00AA, 16'h3333, 16'h4444, 8'd1, 1, 1'b0, 16'h5A5A};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      reset_check("reset");

      // Simultaneous strobes: m0 wins the first tie, then strict alternation.
      ack_at = 8'd1;
      bus.wb_dat_i = 16'hC0DE;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         strobe(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0101);
         strobe(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
         sb.push_back('{1'b0, 1'b0, 16'h0000});
         sb.push_back('{1'b1, 1'b0, 16'hC0DE});
         win = 0; dones = 0; last_stb = -1; prev_stb = 0;
         for (int k = 1; k <= 30 && dones < 2; k++) begin
            @(negedge clk);
            if (k == 1) unstrobe();
            if (bus.wb_stb_o && prev_stb == 0) begin
               chk("tie_grant", {31'd0, grant_o}, (win == 0) ? 32'd0 : 32'd1);
               if (win == 1) chk("tie_gap", k - last_stb - 1, 32'd1);
               win++;
            end
            if (bus.wb_stb_o) last_stb = k;
            prev_stb = bus.wb_stb_o ? 1 : 0;
            if (m0_done || m1_done) dones++;
         end
         chk("tie_windows", win, 32'd2);
      end

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Strobe in the ack cycle of its own slot is accepted, no overrun.
      @(negedge clk);
      ack_at = 8'd2;
      strobe(1'b0, 1'b1, 1'b0, 16'h0200, 16'h4444);
      sb.push_back('{1'b0, 1'b0, 16'h5A5A});
      sb.push_back('{1'b0, 1'b0, 16'h5A5A});
      win = 0; dones = 0; prev_stb = 0; sent = 1'b0;
      win_dat[0] = 16'h0; win_dat[1] = 16'h0;
      for (int k = 1; k <= 30 && dones < 2; k++) begin
         @(negedge clk);
         unstrobe();
         if (bus.wb_stb_o && prev_stb == 0) begin
            if (win < 2) win_dat[win] = bus.wb_dat_o;
            win++;
         end
         prev_stb = bus.wb_stb_o ? 1 : 0;
         if (m0_done || m1_done) dones++;
         if (bus.wb_stb_o && bus.wb_ack_i && !sent) begin
            strobe(1'b0, 1'b1, 1'b0, 16'h0201, 16'h5555);
            sent = 1'b1;
         end
      end
      chk("ackcyc_windows", win, 32'd2);
      chk("ackcyc_dat0", {16'd0, win_dat[0]}, 32'h4444);
      chk("ackcyc_dat1", {16'd0, win_dat[1]}, 32'h5555);
      chk("ackcyc_overrun", {31'd0, m0_overrun}, 32'd0);

      // Second strobe while the first is still pending is dropped and flags overrun.
      @(negedge clk);
      ack_at = 8'd3;
      strobe(1'b0, 1'b1, 1'b0, 16'h0300, 16'h1111);
      sb.push_back('{1'b0, 1'b0, 16'h5A5A});
      win = 0; prev_stb = 0;
      win_dat[0] = 16'h0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         unstrobe();
         if (k == 2) strobe(1'b0, 1'b1, 1'b0, 16'h0301, 16'h2222);
         if (bus.wb_stb_o && prev_stb == 0) begin
            if (win == 0) win_dat[0] = bus.wb_dat_o;
            win++;
         end
         prev_stb = bus.wb_stb_o ? 1 : 0;
      end
      chk("ovr_windows", win, 32'd1);
      chk("ovr_dat", {16'd0, win_dat[0]}, 32'h1111);
      chk("ovr_sticky", {31'd0, m0_overrun}, 32'd1);
      chk("ovr_other", {31'd0, m1_overrun}, 32'd0);

      // Reset on the third stb cycle of a never-acked read.
      @(negedge clk);
      ack_at = 8'd0;
      strobe(1'b1, 1'b0, 1'b1, 16'h0400, 16'h0000);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         unstrobe();
      end
      chk("rstbus_stb_before", {31'd0, bus.wb_stb_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstbus_stb_off", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
      chk("rstbus_no_done", {30'd0, m1_done, m0_done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      reset_check("rstbus");
      prev_stb = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.wb_stb_o) prev_stb = 1;
      end
      chk("rstbus_slots_empty", prev_stb, 32'd0);
      run_vec('{1'b1, 1'b1, 1'b0, 16'h0ABC, 16'h0DEF, 16'h0000, 8'd1, 1, 1'b0, 16'h0000},
              "after_rst");

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
